// File: rtl/gpio_ext.sv
// gpio_ext: NumPins-wide GPIO with a registered bus slave, 2-flop input synchroniser,
// per-pin edge/level interrupts with W1C status. Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter.
module gpio_ext #(
  parameter int NumPins        = 32,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int DebounceCycles = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumPins-1:0]      gpio_in_i,
  output logic [NumPins-1:0]      gpio_out_o,
  output logic [NumPins-1:0]      gpio_oe_o,
  input  logic                    gpio_req_i,
  input  logic [AddressWidth-1:0] gpio_addr_i,
  input  logic                    gpio_we_i,
  input  logic [3:0]              gpio_be_i,
  input  logic [DataWidth-1:0]    gpio_wdata_i,
  output logic                    gpio_rvalid_o,
  output logic [DataWidth-1:0]    gpio_rdata_o,
  output logic                    gpio_err_o,
  output logic                    gpio_intr_o
);

  localparam logic [7:0] IdxInputVal  = 8'h00;
  localparam logic [7:0] IdxInputEn   = 8'h01;
  localparam logic [7:0] IdxOutputEn  = 8'h02;
  localparam logic [7:0] IdxOutputVal = 8'h03;
  localparam logic [7:0] IdxOutXor    = 8'h04;
  localparam logic [7:0] IdxIntrEn    = 8'h05;
  localparam logic [7:0] IdxIntrType  = 8'h06;
  localparam logic [7:0] IdxIntrPol   = 8'h07;
  localparam logic [7:0] IdxIntrStat  = 8'h08;

  logic [NumPins-1:0]   r_sync1;
  logic [NumPins-1:0]   r_sync2;
  logic [NumPins-1:0]   r_sQ;
  logic [NumPins-1:0]   w_filt;

  logic [NumPins-1:0]   r_inputEn;
  logic [NumPins-1:0]   r_outputEn;
  logic [NumPins-1:0]   r_outputVal;
  logic [NumPins-1:0]   r_outXor;
  logic [NumPins-1:0]   r_intrEn;
  logic [NumPins-1:0]   r_intrType;
  logic [NumPins-1:0]   r_intrPol;
  logic [NumPins-1:0]   r_intrStat;
  logic [NumPins-1:0]   r_padOut;

  logic                 r_rvalid;
  logic                 r_err;
  logic                 r_intr;
  logic [DataWidth-1:0] r_rdata;

  logic [7:0]           w_wordIdx;
  logic                 w_err;
  logic                 w_wrEn;
  logic [NumPins-1:0]   w_beMask;
  logic [NumPins-1:0]   w_wdataPins;
  logic [NumPins-1:0]   w_clrMask;
  logic [NumPins-1:0]   w_edgeHit;
  logic [NumPins-1:0]   w_levelHit;
  logic [NumPins-1:0]   w_hit;
  logic [NumPins-1:0]   w_statNext;
  logic [NumPins-1:0]   w_readPins;
  logic [DataWidth-1:0] w_rdataNext;
  logic                 w_unusedBits;

  logic [NumPins-1:0]   w_inputEnNext;
  logic [NumPins-1:0]   w_outputEnNext;
  logic [NumPins-1:0]   w_outputValNext;
  logic [NumPins-1:0]   w_outXorNext;
  logic [NumPins-1:0]   w_intrEnNext;
  logic [NumPins-1:0]   w_intrTypeNext;
  logic [NumPins-1:0]   w_intrPolNext;

  function automatic logic [NumPins-1:0] mergeBytes(input logic [NumPins-1:0] oldVal,
                                                    input logic [NumPins-1:0] newVal,
                                                    input logic [NumPins-1:0] mask);
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  // Address bits above the 1 kB window and wdata bits above NumPins are intentionally ignored.
  assign w_unusedBits = ^{gpio_addr_i, gpio_wdata_i, (DebounceCycles > 0)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sQ    <= '0;
    end else begin
      r_sync1 <= gpio_in_i;
      r_sync2 <= r_sync1;
      r_sQ    <= w_filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CntW = $clog2(DebounceCycles + 1);

  logic [CntW-1:0]    r_dbCnt [NumPins];
  logic [NumPins-1:0] r_filt;

  // A pin's filtered value flips only after the synced value has disagreed with it for DebounceCycles cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_filt <= '0;
      for (int i = 0; i < NumPins; i++) r_dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumPins; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == CntW'(DebounceCycles - 1)) begin
          r_filt[i]  <= r_sync2[i];
          r_dbCnt[i] <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + CntW'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  assign w_wordIdx   = gpio_addr_i[9:2];
  assign w_err       = (gpio_addr_i[1:0] != 2'b00) || (w_wordIdx > IdxIntrStat) ||
                       (gpio_we_i && (w_wordIdx == IdxInputVal));
  assign w_wrEn      = gpio_req_i && gpio_we_i && !w_err;
  assign w_wdataPins = gpio_wdata_i[NumPins-1:0];

  always_comb begin
    w_beMask = '0;
    for (int i = 0; i < NumPins; i++) w_beMask[i] = gpio_be_i[i/8];
  end

  always_comb begin
    w_inputEnNext   = r_inputEn;
    w_outputEnNext  = r_outputEn;
    w_outputValNext = r_outputVal;
    w_outXorNext    = r_outXor;
    w_intrEnNext    = r_intrEn;
    w_intrTypeNext  = r_intrType;
    w_intrPolNext   = r_intrPol;
    w_clrMask       = '0;
    if (w_wrEn) begin
      case (w_wordIdx)
        IdxInputEn:   w_inputEnNext   = mergeBytes(r_inputEn,   w_wdataPins, w_beMask);
        IdxOutputEn:  w_outputEnNext  = mergeBytes(r_outputEn,  w_wdataPins, w_beMask);
        IdxOutputVal: w_outputValNext = mergeBytes(r_outputVal, w_wdataPins, w_beMask);
        IdxOutXor:    w_outXorNext    = mergeBytes(r_outXor,    w_wdataPins, w_beMask);
        IdxIntrEn:    w_intrEnNext    = mergeBytes(r_intrEn,    w_wdataPins, w_beMask);
        IdxIntrType:  w_intrTypeNext  = mergeBytes(r_intrType,  w_wdataPins, w_beMask);
        IdxIntrPol:   w_intrPolNext   = mergeBytes(r_intrPol,   w_wdataPins, w_beMask);
        IdxIntrStat:  w_clrMask       = w_wdataPins & w_beMask;
        default:      w_clrMask       = '0;
      endcase
    end
  end

  // New hits are OR-ed in after the clear, so a same-cycle hit keeps its status bit set.
  assign w_edgeHit  = (r_intrPol & w_filt & ~r_sQ) | (~r_intrPol & ~w_filt & r_sQ);
  assign w_levelHit = ~(w_filt ^ r_intrPol);
  assign w_hit      = (r_intrType & w_edgeHit) | (~r_intrType & w_levelHit);
  assign w_statNext = (r_intrStat & ~w_clrMask) | w_hit;

  always_comb begin
    w_readPins = '0;
    case (w_wordIdx)
      IdxInputVal:  w_readPins = w_filt & r_inputEn;
      IdxInputEn:   w_readPins = r_inputEn;
      IdxOutputEn:  w_readPins = r_outputEn;
      IdxOutputVal: w_readPins = r_outputVal;
      IdxOutXor:    w_readPins = r_outXor;
      IdxIntrEn:    w_readPins = r_intrEn;
      IdxIntrType:  w_readPins = r_intrType;
      IdxIntrPol:   w_readPins = r_intrPol;
      IdxIntrStat:  w_readPins = r_intrStat;
      default:      w_readPins = '0;
    endcase
    w_rdataNext = '0;
    if (!w_err && !gpio_we_i) w_rdataNext[NumPins-1:0] = w_readPins;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inputEn   <= '0;
      r_outputEn  <= '0;
      r_outputVal <= '0;
      r_outXor    <= '0;
      r_intrEn    <= '0;
      r_intrType  <= '0;
      r_intrPol   <= '0;
      r_intrStat  <= '0;
      r_padOut    <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_intr      <= 1'b0;
    end else begin
      r_inputEn   <= w_inputEnNext;
      r_outputEn  <= w_outputEnNext;
      r_outputVal <= w_outputValNext;
      r_outXor    <= w_outXorNext;
      r_intrEn    <= w_intrEnNext;
      r_intrType  <= w_intrTypeNext;
      r_intrPol   <= w_intrPolNext;
      r_intrStat  <= w_statNext;
      r_padOut    <= w_outputValNext ^ w_outXorNext;
      r_rvalid    <= gpio_req_i;
      r_intr      <= |(r_intrStat & r_intrEn);
      if (gpio_req_i) begin
        r_err   <= w_err;
        r_rdata <= w_rdataNext;
      end
    end
  end

  assign gpio_out_o    = r_padOut;
  assign gpio_oe_o     = r_outputEn;
  assign gpio_rvalid_o = r_rvalid;
  assign gpio_rdata_o  = r_rdata;
  assign gpio_err_o    = r_err;
  assign gpio_intr_o   = r_intr;

endmodule
